// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, FSM state type and twiddle tag function for the FFT stage sequencer
package fft_pkg;

  localparam int N_LOG2 = 6;
  localparam int N      = 1 << N_LOG2;
  localparam int DW     = 16;
  localparam int IW     = N_LOG2 - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          en;
    logic [IW-1:0] idx;
  } tw_tag_t;

  // Butterfly span at stage s is 2*half = N>>s; samples in the upper half of
  // each span are butterfly lower outputs and take W^((pos-half)<<s).
  function automatic tw_tag_t tw_tag(input logic [N_LOG2-1:0] n, input logic [2:0] s);
    tw_tag_t           t;
    logic [N_LOG2:0]   two_half;
    logic [N_LOG2-1:0] half;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] diff;
    two_half = {1'b1, {N_LOG2{1'b0}}} >> s;
    half     = N_LOG2'(two_half >> 1);
    pos      = n & N_LOG2'(two_half - 1'b1);
    diff     = pos - half;
    t.en     = (pos >= half);
    t.idx    = t.en ? IW'(diff << s) : '0;
    return t;
  endfunction

endpackage

// File: rtl/fft_twiddle_sched_if.sv
// rtl/fft_twiddle_sched_if.sv - sample input and tagged output stream bundle
// master: stream source / sink side (drives in_*, out_ready)
// slave : sequencer side (drives in_ready, out_*)
interface fft_twiddle_sched_if;
  import fft_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [IW-1:0] out_tw_idx;
  logic          out_tw_en;
  logic          out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_tw_idx, out_tw_en, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_tw_idx, out_tw_en, out_last
  );
endinterface

// File: rtl/fft_pipe_reg.sv
// rtl/fft_pipe_reg.sv - one-entry valid/ready output register
// clk, rst_n : clock, async active-low reset
// clr_i      : drop held entry (valid only; data kept)
// load_i     : capture data_i this cycle (caller guarantees room)
// ready_i    : downstream accepts the held entry
// valid_o    : entry held
// data_o     : held payload
module fft_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load wins over drain so a draining entry can be replaced in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fft_twiddle_sched.sv
// rtl/fft_twiddle_sched.sv - per-stage twiddle tagging sequencer for a radix-2 DIF FFT
// clk, rst_n : clock, async active-low reset
// start      : begin one frame (IDLE only); stage latched with it
// stage      : stage number 0..N_LOG2-1
// abort      : drop current frame, back to IDLE, no done
// busy       : not IDLE
// done       : one-cycle pulse after the last sample leaves
// cfg_err    : one-cycle pulse after a start with an illegal stage
// bus        : sample stream in, tagged sample stream out
module fft_twiddle_sched
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          stage,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  fft_twiddle_sched_if.slave  bus
);
  localparam int PW = 2 * DW + IW + 2;

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] n_q, n_d;
  logic [2:0]        stage_q, stage_d;
  logic              cfg_err_q, cfg_err_d;
  logic              fire;
  logic              out_fire;
  logic              pipe_valid;
  logic [PW-1:0]     pipe_in;
  logic [PW-1:0]     pipe_out;
  tw_tag_t           tag;

  assign tag      = tw_tag(n_q, stage_q);
  assign out_fire = pipe_valid && bus.out_ready;
  // Abort gates in_ready so an input is never reported accepted and then dropped.
  assign bus.in_ready = (state_q == RUN) && !abort && (!pipe_valid || bus.out_ready);
  assign fire     = bus.in_valid && bus.in_ready;
  assign pipe_in  = {bus.in_re, bus.in_im, tag.idx, tag.en, (&n_q)};

  fft_pipe_reg #(.W(PW)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (abort),
    .load_i  (fire),
    .data_i  (pipe_in),
    .ready_i (bus.out_ready),
    .valid_o (pipe_valid),
    .data_o  (pipe_out)
  );

  assign bus.out_valid = pipe_valid;
  assign {bus.out_re, bus.out_im, bus.out_tw_idx, bus.out_tw_en, bus.out_last} = pipe_out;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    stage_d   = stage_q;
    cfg_err_d = 1'b0;
    if (abort) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        n_d     = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (stage < 3'(N_LOG2)) begin
              stage_d = stage;
              n_d     = '0;
              state_d = RUN;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            n_d = n_q + 1'b1;
            if (&n_q) state_d = DRAIN;
          end
        end
        DRAIN: if (out_fire) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      stage_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      stage_q   <= stage_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) && !abort;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_fft_twiddle_sched.sv
// tb/tb_fft_twiddle_sched.sv - directed self-checking bench for fft_twiddle_sched
module tb_fft_twiddle_sched;
  import fft_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] stage;
  logic       abort;
  logic       busy;
  logic       done;
  logic       cfg_err;

  fft_twiddle_sched_if bus();

  fft_twiddle_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stage   (stage),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] cap_re   [N];
  logic [DW-1:0] cap_im   [N];
  logic          cap_en   [N];
  logic [IW-1:0] cap_idx  [N];
  logic          cap_last [N];
  int            got;
  int            done_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream one full frame; optional 3-cycle output stall at sample 10 and a
  // start pulse (with a different stage) in the middle of RUN.
  task automatic run_frame(input logic [2:0] s, input bit stall, input bit restart);
    int  cyc, sent, stall_left;
    bit  stalled;
    got = 0; done_cyc = -1; sent = 0; cyc = 0; stall_left = 0; stalled = 0;
    bus.out_ready = 1'b1;
    stage = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      bus.in_valid = (sent < N);
      bus.in_re    = DW'(sent);
      bus.in_im    = ~DW'(sent);
      start        = restart && (cyc == 3);
      stage        = (restart && cyc == 3) ? 3'd3 : s;
      if (stall && !stalled && bus.out_valid && bus.out_re == 16'd10) begin
        stall_left = 3;
        stalled    = 1;
      end
      bus.out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_hold_re", 64'(bus.out_re), 64'd10);
        chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < N) begin
          cap_re[got]   = bus.out_re;
          cap_im[got]   = bus.out_im;
          cap_en[got]   = bus.out_tw_en;
          cap_idx[got]  = bus.out_tw_idx;
          cap_last[got] = bus.out_last;
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (done) done_cyc = cyc;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; stage = s; bus.in_valid = 1'b0;
    chk("frame_done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic frame_checks(input logic [2:0] s);
    int ramp_bad, tag_bad, last_bad;
    tw_tag_t t;
    ramp_bad = 0; tag_bad = 0; last_bad = 0;
    chk("out_count", 64'(got), 64'(N));
    for (int i = 0; i < N; i++) begin
      t = tw_tag(N_LOG2'(i), s);
      if (cap_re[i] !== DW'(i)) ramp_bad++;
      if (cap_en[i] !== t.en || cap_idx[i] !== t.idx) tag_bad++;
      if (cap_last[i] !== (i == N - 1)) last_bad++;
    end
    chk("ramp_no_loss_dup", 64'(ramp_bad), 64'd0);
    chk("tag_vs_model", 64'(tag_bad), 64'd0);
    chk("last_only_at_63", 64'(last_bad), 64'd0);
  endtask

  task automatic stage0_checks();
    chk("s0_n5_en", 64'(cap_en[5]), 64'd0);
    chk("s0_n5_idx", 64'(cap_idx[5]), 64'd0);
    chk("s0_n5_im", 64'(cap_im[5]), 64'hFFFA);
    chk("s0_n32_en", 64'(cap_en[32]), 64'd1);
    chk("s0_n32_idx", 64'(cap_idx[32]), 64'd0);
    chk("s0_n33_en", 64'(cap_en[33]), 64'd1);
    chk("s0_n33_idx", 64'(cap_idx[33]), 64'd1);
    chk("s0_n63_en", 64'(cap_en[63]), 64'd1);
    chk("s0_n63_idx", 64'(cap_idx[63]), 64'd31);
    chk("s0_n63_last", 64'(cap_last[63]), 64'd1);
    chk("s0_done_cycle", 64'(done_cyc), 64'd65);
    frame_checks(3'd0);
  endtask

  initial begin
    int sent, done_cnt, bad;
    rst_n = 1'b0; start = 1'b0; stage = 3'd0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 1'b1;
    #1;
    chk("reset_outputs",
        64'({busy, done, cfg_err, bus.in_ready, bus.out_valid, bus.out_re, bus.out_im,
             bus.out_tw_idx, bus.out_tw_en, bus.out_last}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stage 0, free-flowing
    run_frame(3'd0, 1'b0, 1'b0);
    stage0_checks();

    // stage 2
    run_frame(3'd2, 1'b0, 1'b0);
    chk("s2_n8_en", 64'(cap_en[8]), 64'd1);
    chk("s2_n8_idx", 64'(cap_idx[8]), 64'd0);
    chk("s2_n9_idx", 64'(cap_idx[9]), 64'd4);
    chk("s2_n15_idx", 64'(cap_idx[15]), 64'd28);
    chk("s2_n16_en", 64'(cap_en[16]), 64'd0);
    chk("s2_n24_en", 64'(cap_en[24]), 64'd1);
    chk("s2_n24_idx", 64'(cap_idx[24]), 64'd0);
    frame_checks(3'd2);

    // stage 5 with a start (stage 3) pulsed mid-RUN that must be ignored
    run_frame(3'd5, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < N; i++)
      if (cap_en[i] !== 1'(i % 2) || cap_idx[i] !== '0) bad++;
    chk("s5_even_odd_pattern", 64'(bad), 64'd0);
    chk("s5_done_cycle", 64'(done_cyc), 64'd65);
    frame_checks(3'd5);

    // stage 1 with 3-cycle backpressure at n=10
    run_frame(3'd1, 1'b1, 1'b0);
    chk("s1_n10_en", 64'(cap_en[10]), 64'd0);
    chk("s1_n17_idx", 64'(cap_idx[17]), 64'd2);
    chk("s1_done_cycle", 64'(done_cyc), 64'd68);
    frame_checks(3'd1);

    // illegal stage
    stage = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
    chk("cfg_err_not_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("cfg_err_one_cycle", 64'(cfg_err), 64'd0);

    // abort and start together: frame must not start
    stage = 3'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 64'(busy), 64'd0);

    // abort at n=20
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 100 && sent < 20; c++) begin
      bus.in_valid = 1'b1; bus.in_re = DW'(sent); bus.in_im = ~DW'(sent);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("abort_reached_n20", 64'(sent), 64'd20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);

    // async reset at n=40
    stage = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 100 && sent < 40; c++) begin
      bus.in_valid = 1'b1; bus.in_re = DW'(sent); bus.in_im = ~DW'(sent);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        64'({busy, done, cfg_err, bus.in_ready, bus.out_valid, bus.out_re, bus.out_im,
             bus.out_tw_idx, bus.out_tw_en, bus.out_last}), 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean frame after reset matches the first one
    run_frame(3'd0, 1'b0, 1'b0);
    stage0_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
